// File: rtl/ysyx_23060203_alu_arb.sv
// Two-requester arbiter in front of one shared combinational ALU.
// Macro YSYX_23060203_ALU_ARB_RR_EN selects round-robin, else fixed priority.
//
// Ports:
//   clock, reset          rising-edge clock, async active-high reset
//   reqN_valid/ready      request handshake (N = 0, 1)
//   reqN_a/b/funct/sw     operation payload of requester N
//   respN_valid/ready     response handshake of requester N
//   respN_val             shared result register
//   alu_a/b/funct/sw      operand registers driven to the shared ALU
//   alu_val               combinational result from the shared ALU
module ysyx_23060203_alu_arb (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_funct,
  input  logic        req0_sw,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_funct,
  input  logic        req1_sw,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic [31:0] resp0_val,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [31:0] resp1_val,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_funct,
  output logic        alu_sw,
  input  logic [31:0] alu_val
);

  localparam logic [2:0] S_IDLE = 3'b001;
  localparam logic [2:0] S_EXEC = 3'b010;
  localparam logic [2:0] S_RESP = 3'b100;

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [2:0]  op_funct;
  logic        op_sw;
  logic [31:0] res;
  logic        owner;

  logic        is_idle;
  logic        is_exec;
  logic        is_resp;
  logic        grant;
  logic        accept;
  logic        resp_hs;

  assign is_idle = state[0];
  assign is_exec = state[1];
  assign is_resp = state[2];

`ifdef YSYX_23060203_ALU_ARB_RR_EN
  // ptr holds the last winner; a tie goes to the other requester.
  logic ptr;

  assign grant = (req0_valid & req1_valid) ? ~ptr
                                           : ~req0_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr <= 1'b1;
    end else if (accept) begin
      ptr <= grant;
    end
  end
`else
  assign grant = ~req0_valid;
`endif

  // Ready is masked by reset so nothing is offered while reset is held.
  assign req0_ready = is_idle & ~reset
                    & req0_valid & ~grant;
  assign req1_ready = is_idle & ~reset
                    & req1_valid & grant;

  assign accept = req0_ready | req1_ready;

  assign resp_hs = is_resp
                 & (owner ? resp1_ready
                          : resp0_ready);

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      state[0]: if (accept) state_nxt = S_EXEC;
      state[1]: state_nxt = S_RESP;
      state[2]: if (resp_hs) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      op_a     <= 32'd0;
      op_b     <= 32'd0;
      op_funct <= 3'd0;
      op_sw    <= 1'b0;
      owner    <= 1'b0;
      res      <= 32'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_a     <= grant ? req1_a : req0_a;
        op_b     <= grant ? req1_b : req0_b;
        op_funct <= grant ? req1_funct
                          : req0_funct;
        op_sw    <= grant ? req1_sw : req0_sw;
        owner    <= grant;
      end
      if (is_exec) begin
        res <= alu_val;
      end
    end
  end

  assign alu_a     = op_a;
  assign alu_b     = op_b;
  assign alu_funct = op_funct;
  assign alu_sw    = op_sw;

  assign resp0_valid = is_resp & ~owner;
  assign resp1_valid = is_resp & owner;
  assign resp0_val   = res;
  assign resp1_val   = res;

endmodule

// File: tb/tb_ysyx_23060203_alu_arb.sv
// Self-checking bench for ysyx_23060203_alu_arb.
// Transaction-level model checked every cycle plus directed literal checks.
module tb_ysyx_23060203_alu_arb;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_a, req0_b;
  logic [2:0]  req0_funct;
  logic        req0_sw;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_a, req1_b;
  logic [2:0]  req1_funct;
  logic        req1_sw;
  logic        resp0_valid, resp0_ready;
  logic [31:0] resp0_val;
  logic        resp1_valid, resp1_ready;
  logic [31:0] resp1_val;
  logic [31:0] alu_a, alu_b, alu_val;
  logic [2:0]  alu_funct;
  logic        alu_sw;

  always #5 clock = ~clock;

  ysyx_23060203_alu_arb dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b),
    .req0_funct(req0_funct), .req0_sw(req0_sw),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b),
    .req1_funct(req1_funct), .req1_sw(req1_sw),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp0_val(resp0_val),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp1_val(resp1_val),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_funct(alu_funct), .alu_sw(alu_sw),
    .alu_val(alu_val)
  );

  function automatic logic [31:0] alu_model(
    input logic [31:0] a, input logic [31:0] b,
    input logic [2:0] f, input logic sw);
    case (f)
      3'd0: return sw ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return {31'd0, $signed(a) < $signed(b)};
      3'd3: return {31'd0, a < b};
      3'd4: return a ^ b;
      3'd5: return sw ? 32'($signed(a) >>> b[4:0])
                      : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // The shared ALU lives in the bench.
  assign alu_val = alu_model(alu_a, alu_b, alu_funct, alu_sw);

  int n_chk = 0;
  int n_fail = 0;

  // Model: an operation is either absent or some cycles past acceptance.
  bit          m_busy;
  int          m_age;
  int          m_owner;
  int          m_last;
  logic [31:0] m_a, m_b, m_res;
  logic [2:0]  m_f;
  logic        m_sw;
  int          glog[$];
  bit          took0, took1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_age = 0; m_owner = 0; m_last = 1;
    m_a = 0; m_b = 0; m_f = 0; m_sw = 0; m_res = 0;
  endtask

  // Called at the falling edge: compare, then advance the model.
  task automatic sample();
    int g;
    @(negedge clock);
    if (reset) model_reset();
    g = -1;
    if (!m_busy && !reset) begin
      if (req0_valid && req1_valid) begin
`ifdef YSYX_23060203_ALU_ARB_RR_EN
        g = (m_last == 0) ? 1 : 0;
`else
        g = 0;
`endif
      end else if (req0_valid) g = 0;
      else if (req1_valid) g = 1;
    end
    chk("req0_ready", 32'(req0_ready), 32'(g == 0));
    chk("req1_ready", 32'(req1_ready), 32'(g == 1));
    chk("resp0_valid", 32'(resp0_valid),
        32'(m_busy && m_age == 2 && m_owner == 0));
    chk("resp1_valid", 32'(resp1_valid),
        32'(m_busy && m_age == 2 && m_owner == 1));
    chk("resp0_val", resp0_val, m_res);
    chk("resp1_val", resp1_val, m_res);
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    chk("alu_funct", 32'(alu_funct), 32'(m_f));
    chk("alu_sw", 32'(alu_sw), 32'(m_sw));
    if (req0_valid && req0_ready) begin
      glog.push_back(0); took0 = 1;
    end
    if (req1_valid && req1_ready) begin
      glog.push_back(1); took1 = 1;
    end
    if (!reset) begin
      if (g >= 0) begin
        m_busy = 1; m_age = 1; m_owner = g; m_last = g;
        m_a  = g ? req1_a : req0_a;
        m_b  = g ? req1_b : req0_b;
        m_f  = g ? req1_funct : req0_funct;
        m_sw = g ? req1_sw : req0_sw;
      end else if (m_busy && m_age == 1) begin
        m_res = alu_model(m_a, m_b, m_f, m_sw);
        m_age = 2;
      end else if (m_busy && m_age == 2) begin
        if (m_owner == 0 ? resp0_ready : resp1_ready)
          m_busy = 0;
      end
    end
  endtask

  task automatic adv();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] rnd();
    case ($urandom_range(0, 3))
      0: return 32'($urandom_range(0, 40));
      1: return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      2: return {1'b1, 31'($urandom)};
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic drive_rand();
    if (!req0_valid || took0) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req0_a = rnd(); req0_b = rnd();
      req0_funct = 3'($urandom_range(0, 7));
      req0_sw = 1'($urandom_range(0, 1));
    end
    if (!req1_valid || took1) begin
      req1_valid = ($urandom_range(0, 3) != 0);
      req1_a = rnd(); req1_b = rnd();
      req1_funct = 3'($urandom_range(0, 7));
      req1_sw = 1'($urandom_range(0, 1));
    end
    took0 = 0; took1 = 0;
  endtask

  // Three-cycle op with the owner ready; checks the literal result.
  task automatic one_op(input int who,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [2:0] f,
                        input logic sw,
                        input logic [31:0] exp,
                        input string nm);
    if (who == 0) begin
      req0_valid = 1; req0_a = a; req0_b = b;
      req0_funct = f; req0_sw = sw;
    end else begin
      req1_valid = 1; req1_a = a; req1_b = b;
      req1_funct = f; req1_sw = sw;
    end
    sample(); adv();
    req0_valid = 0; req1_valid = 0;
    sample();
    chk({nm, "_alu_a"}, alu_a, a);
    chk({nm, "_alu_b"}, alu_b, b);
    chk({nm, "_alu_f"}, 32'(alu_funct), 32'(f));
    chk({nm, "_alu_sw"}, 32'(alu_sw), 32'(sw));
    adv();
    sample();
    if (who == 0) begin
      chk({nm, "_vld"}, 32'(resp0_valid), 32'd1);
      chk({nm, "_val"}, resp0_val, exp);
      chk({nm, "_other"}, 32'(resp1_valid), 32'd0);
    end else begin
      chk({nm, "_vld"}, 32'(resp1_valid), 32'd1);
      chk({nm, "_val"}, resp1_val, exp);
      chk({nm, "_other"}, 32'(resp0_valid), 32'd0);
    end
    adv();
  endtask

  int exp_g[4];

  initial begin
    req0_valid = 0; req0_a = 0; req0_b = 0;
    req0_funct = 0; req0_sw = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0;
    req1_funct = 0; req1_sw = 0;
    resp0_ready = 0; resp1_ready = 0;
    took0 = 0; took1 = 0;
    model_reset();
    reset = 1;
    adv();

    // Reset values, even with a requester valid.
    req0_valid = 1;
    sample();
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_resp0", 32'(resp0_valid), 32'd0);
    adv();
    req0_valid = 0;
    reset = 0;

    resp0_ready = 1; resp1_ready = 1;
    one_op(0, 32'd5, 32'd3, 3'd0, 1'b1, 32'd2, "sub");
    one_op(1, 32'hFFFF_FFFF, 32'd1, 3'd2, 1'b0,
           32'd1, "lts");
    one_op(1, 32'hFFFF_FFFF, 32'd1, 3'd3, 1'b0,
           32'd0, "ltu");
    one_op(0, 32'h8000_0000, 32'd4, 3'd5, 1'b1,
           32'hF800_0000, "sra");

    // Tie: both requesters keep valid for four operations.
    reset = 1; sample(); adv(); reset = 0;
    glog.delete();
    req0_valid = 1; req0_a = 32'd1; req0_b = 32'd1;
    req0_funct = 0; req0_sw = 0;
    req1_valid = 1; req1_a = 32'd2; req1_b = 32'd2;
    req1_funct = 0; req1_sw = 0;
    for (int i = 0; i < 12; i++) begin
      sample(); adv();
      if (took0) req0_a = req0_a + 32'd10;
      if (took1) req1_a = req1_a + 32'd10;
      took0 = 0; took1 = 0;
    end
    req0_valid = 0; req1_valid = 0;
`ifdef YSYX_23060203_ALU_ARB_RR_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    chk("tie_count", 32'(glog.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("tie_grant%0d", i),
          (i < glog.size()) ? 32'(glog[i]) : 32'hDEAD,
          32'(exp_g[i]));
    end

    // Backpressure on resp0 with the non-owner ready high.
    resp0_ready = 0; resp1_ready = 1;
    req0_valid = 1; req0_a = 32'hF0; req0_b = 32'h0F;
    req0_funct = 3'd6; req0_sw = 0;
    sample(); adv();
    req0_valid = 0;
    req1_valid = 1; req1_a = 32'd7; req1_b = 32'd9;
    req1_funct = 3'd0; req1_sw = 0;
    sample();
    chk("bp_exec_r1", 32'(req1_ready), 32'd0);
    adv();
    for (int i = 0; i < 5; i++) begin
      sample();
      chk("bp_vld", 32'(resp0_valid), 32'd1);
      chk("bp_val", resp0_val, 32'hFF);
      chk("bp_r1", 32'(req1_ready), 32'd0);
      adv();
    end
    resp0_ready = 1;
    sample();
    chk("bp_last_r1", 32'(req1_ready), 32'd0);
    adv();
    sample();
    chk("bp_idle_r1", 32'(req1_ready), 32'd1);
    adv();
    req1_valid = 0;
    sample(); adv();
    sample();
    chk("bp_r1_val", resp1_val, 32'd16);
    adv();

    // Reset while an operation sits in EXEC.
    req0_valid = 1; req0_a = 32'd123; req0_b = 32'd77;
    req0_funct = 3'd4; req0_sw = 1;
    sample(); adv();
    req0_valid = 0; req1_valid = 1;
    reset = 1;
    sample();
    chk("rx_alu_a", alu_a, 32'd0);
    chk("rx_alu_b", alu_b, 32'd0);
    chk("rx_alu_f", 32'(alu_funct), 32'd0);
    chk("rx_alu_sw", 32'(alu_sw), 32'd0);
    chk("rx_r1", 32'(req1_ready), 32'd0);
    chk("rx_v0", 32'(resp0_valid), 32'd0);
    adv();
    reset = 0; req1_valid = 0;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("rx_after_v0", 32'(resp0_valid), 32'd0);
      chk("rx_after_v1", 32'(resp1_valid), 32'd0);
      adv();
    end

    // Random traffic with random backpressure and rare resets.
    took0 = 0; took1 = 0;
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 149) == 0);
      drive_rand();
      resp0_ready = ($urandom_range(0, 3) != 0);
      resp1_ready = ($urandom_range(0, 3) != 0);
      sample();
      adv();
    end
    reset = 0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
